ws2812_chain_ctrl: RTL and testbench

//  UART-commanded controller for a chain of NUM_LEDS WS2812-type RGB LEDs. It is the multi-LED, parametrised

---
 rtl/ws2812_chain_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_ws2812_chain_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_chain_ctrl.sv
// ws2812_chain_ctrl
//   UART-commanded controller for a chain of NUM_LEDS WS2812-type RGB LEDs.
//   Parses colour-write frames (A5 idx R G B) and show requests (5A) from a
//   received byte stream. Holds one 24-bit {G,R,B} word per LED. On show it
//   serialises the whole chain in RZ format, MSB first, LED 0 first, and then
//   holds the line low for the latch gap.
//
//   Ports
//     clk        system clock
//     rst_n      asynchronous active-low reset
//     rx_data    received UART byte
//     rx_valid   1-cycle strobe, rx_data valid
//     rz_data    serial RZ output to the first LED
//     busy       high while a frame (bits + latch gap) is being sent
//     frame_done 1-cycle pulse in the last latch-gap cycle
//     cmd_err    1-cycle pulse on a bad LED index or an inter-byte timeout
module ws2812_chain_ctrl #(
    parameter int NUM_LEDS    = 8,
    parameter int BIT_CYC     = 63,
    parameter int T0H_CYC     = 15,
    parameter int T1H_CYC     = 40,
    parameter int RESET_CYC   = 15000,
    parameter int TIMEOUT_CYC = 500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rz_data,
    output logic       busy,
    output logic       frame_done,
    output logic       cmd_err
);

    localparam int LED_W     = $clog2(NUM_LEDS + 1);
    // The buffer is padded to a power of two so the next-LED lookahead index
    // can never point outside the array.
    localparam int IDX_W     = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int BUF_DEPTH = 1 << IDX_W;
    localparam int CNT_MAX_A = (BIT_CYC > RESET_CYC) ? BIT_CYC : RESET_CYC;
    localparam int CNT_MAX   = (CNT_MAX_A > TIMEOUT_CYC) ? CNT_MAX_A : TIMEOUT_CYC;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BIT_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(RESET_CYC - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] T0H_LEN  = CNT_W'(T0H_CYC);
    localparam logic [CNT_W-1:0] T1H_LEN  = CNT_W'(T1H_CYC);
    localparam logic [8:0]       LED_NUM  = 9'(NUM_LEDS);
    localparam logic [LED_W-1:0] LED_LAST = LED_W'(NUM_LEDS - 1);

    typedef enum logic [2:0] {P_IDLE, P_IDX, P_R, P_G, P_B} p_state_t;
    typedef enum logic [2:0] {T_IDLE, T_LOAD, T_HIGH, T_LOW, T_GAP} t_state_t;

    p_state_t          p_state;
    logic [7:0]        idx;
    logic [7:0]        red;
    logic [7:0]        grn;
    logic [CNT_W-1:0]  to_cnt;
    logic [23:0]       buf_mem [BUF_DEPTH];

    t_state_t          t_state;
    logic              pending;
    logic [CNT_W-1:0]  cyc;
    logic [4:0]        bit_cnt;
    logic [LED_W-1:0]  led_cnt;
    logic [23:0]       sh_word;

    logic              show_req;
    logic [CNT_W-1:0]  cyc_inc;
    logic [CNT_W-1:0]  high_len;
    logic [IDX_W-1:0]  led_nxt_idx;

    // 0x5A is a show request only between frames; inside a frame it is data.
    assign show_req    = rx_valid && (p_state == P_IDLE) && (rx_data == 8'h5A);
    assign cyc_inc     = cyc + 1'b1;
    assign high_len    = sh_word[23] ? T1H_LEN : T0H_LEN;
    assign led_nxt_idx = led_cnt[IDX_W-1:0] + 1'b1;

    // Command parser and colour buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_state <= P_IDLE;
            idx     <= '0;
            red     <= '0;
            grn     <= '0;
            to_cnt  <= '0;
            cmd_err <= 1'b0;
            // NOTE: the colour buffer is reset explicitly because the LEDs must
            // read black after any reset, so it cannot map onto a plain RAM.
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_mem[i] <= '0;
            end
        end else begin
            // NOTE: every state register uses <= so all blocks see the
            // pre-edge values regardless of evaluation order.
            cmd_err <= 1'b0;
            if (rx_valid) begin
                to_cnt <= '0;
                case (p_state)
                    P_IDLE: if (rx_data == 8'hA5) p_state <= P_IDX;
                    P_IDX: begin
                        idx     <= rx_data;
                        p_state <= P_R;
                    end
                    P_R: begin
                        red     <= rx_data;
                        p_state <= P_G;
                    end
                    P_G: begin
                        grn     <= rx_data;
                        p_state <= P_B;
                    end
                    P_B: begin
                        if ({1'b0, idx} < LED_NUM) begin
                            buf_mem[idx[IDX_W-1:0]] <= {grn, red, rx_data};
                        end else begin
                            cmd_err <= 1'b1;
                        end
                        p_state <= P_IDLE;
                    end
                    default: p_state <= P_IDLE;
                endcase
            end else if (p_state != P_IDLE) begin
                // Partial frame stalled: drop it and flag the error.
                if (to_cnt == TO_LAST) begin
                    p_state <= P_IDLE;
                    cmd_err <= 1'b1;
                    to_cnt  <= '0;
                end else begin
                    to_cnt <= cyc_inc_to(to_cnt);
                end
            end else begin
                to_cnt <= '0;
            end
        end
    end

    function automatic logic [CNT_W-1:0] cyc_inc_to(input logic [CNT_W-1:0] v);
        return v + 1'b1;
    endfunction

    // RZ transmitter. rz_data is registered, so each state sets the level
    // that appears in the following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_state    <= T_IDLE;
            rz_data    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            pending    <= 1'b0;
            cyc        <= '0;
            bit_cnt    <= '0;
            led_cnt    <= '0;
            sh_word    <= '0;
        end else begin
            frame_done <= 1'b0;
            if (show_req && (t_state != T_IDLE)) pending <= 1'b1;
            case (t_state)
                T_IDLE: begin
                    if (show_req) begin
                        t_state <= T_LOAD;
                        busy    <= 1'b1;
                    end
                end
                T_LOAD: begin
                    sh_word <= buf_mem[0];
                    led_cnt <= '0;
                    bit_cnt <= '0;
                    cyc     <= '0;
                    rz_data <= 1'b1;
                    t_state <= T_HIGH;
                end
                T_HIGH: begin
                    cyc <= cyc_inc;
                    if (cyc_inc == high_len) begin
                        rz_data <= 1'b0;
                        t_state <= T_LOW;
                    end
                end
                T_LOW: begin
                    if (cyc == BIT_LAST) begin
                        cyc <= '0;
                        if (bit_cnt == 5'd23) begin
                            if (led_cnt == LED_LAST) begin
                                t_state    <= T_GAP;
                                frame_done <= (RESET_CYC == 1);
                            end else begin
                                // Next LED's word is fetched here so bit 0
                                // follows bit 23 with no idle cycle.
                                led_cnt <= led_cnt + 1'b1;
                                bit_cnt <= '0;
                                sh_word <= buf_mem[led_nxt_idx];
                                rz_data <= 1'b1;
                                t_state <= T_HIGH;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                            sh_word <= {sh_word[22:0], 1'b0};
                            rz_data <= 1'b1;
                            t_state <= T_HIGH;
                        end
                    end else begin
                        cyc <= cyc_inc;
                    end
                end
                T_GAP: begin
                    if (cyc == GAP_LAST) begin
                        cyc <= '0;
                        if (pending || show_req) begin
                            pending <= 1'b0;
                            t_state <= T_LOAD;
                        end else begin
                            busy    <= 1'b0;
                            t_state <= T_IDLE;
                        end
                    end else begin
                        cyc        <= cyc_inc;
                        frame_done <= (cyc_inc == GAP_LAST);
                    end
                end
                default: t_state <= T_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_chain_ctrl.sv
// tb_ws2812_chain_ctrl
//   Self-checking bench for ws2812_chain_ctrl with a short chain and short
//   timings. A colour-buffer model is updated from the commands sent; the RZ
//   waveform is decoded back into 24-bit words per LED and compared.
module tb_ws2812_chain_ctrl;

    localparam int N         = 4;
    localparam int BC        = 10;
    localparam int T0        = 3;
    localparam int T1        = 7;
    localparam int RC        = 40;
    localparam int TO        = 300;
    localparam int FRAME_LEN = N * 24 * BC + RC;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rz_data;
    logic       busy;
    logic       frame_done;
    logic       cmd_err;

    int          checks = 0;
    int          failures = 0;
    logic [23:0] exp_buf [N];

    ws2812_chain_ctrl #(
        .NUM_LEDS   (N),
        .BIT_CYC    (BC),
        .T0H_CYC    (T0),
        .T1H_CYC    (T1),
        .RESET_CYC  (RC),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rz_data   (rz_data),
        .busy      (busy),
        .frame_done(frame_done),
        .cmd_err   (cmd_err)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Byte is accepted at the posedge inside this task; returns at the
    // following negedge, where a registered cmd_err for that byte is visible.
    task automatic send_byte(input logic [7:0] b, output logic err);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        err      = cmd_err;
    endtask

    function automatic logic [7:0] rnd_byte();
        if ($urandom_range(0, 3) == 0) return ($urandom_range(0, 1) != 0) ? 8'hA5 : 8'h5A;
        return 8'($urandom);
    endfunction

    task automatic write_led(input int idx, input logic [7:0] r, input logic [7:0] g,
                             input logic [7:0] b, input string tag);
        logic e;
        int   early = 0;
        logic [7:0] bytes [4];
        bytes[0] = 8'hA5;
        bytes[1] = 8'(idx);
        bytes[2] = r;
        bytes[3] = g;
        for (int i = 0; i < 4; i++) begin
            send_byte(bytes[i], e);
            early += int'(e);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        send_byte(b, e);
        check(tag, (early << 1) | int'(e), (idx >= N) ? 1 : 0);
        if (idx < N) exp_buf[idx] = {g, r, b};
    endtask

    // Entered at the negedge of the T_LOAD cycle; samples one whole frame.
    task automatic capture_frame(input string tag);
        bit          wave [FRAME_LEN];
        logic [23:0] snap [N];
        logic [23:0] word;
        int busy_low = 0, fd_cnt = 0, fd_last = 0, bad_shape = 0, gap_ones = 0;
        for (int l = 0; l < N; l++) snap[l] = exp_buf[l];
        check({tag, "_start"}, {busy, rz_data}, 2'b10);
        for (int i = 0; i < FRAME_LEN; i++) begin
            @(negedge clk);
            wave[i] = rz_data;
            if (!busy) busy_low++;
            if (frame_done) begin
                fd_cnt++;
                if (i == FRAME_LEN - 1) fd_last = 1;
            end
        end
        for (int l = 0; l < N; l++) begin
            word = '0;
            for (int bi = 0; bi < 24; bi++) begin
                int base, h, ones;
                base = (l * 24 + bi) * BC;
                h    = 0;
                ones = 0;
                for (int c = 0; c < BC; c++) begin
                    if (wave[base + c]) begin
                        ones++;
                        if (h == c) h++;
                    end
                end
                if (ones != h || (h != T0 && h != T1)) bad_shape++;
                word = {word[22:0], (h == T1)};
            end
            check($sformatf("%s_led%0d", tag, l), word, snap[l]);
        end
        for (int i = N * 24 * BC; i < FRAME_LEN; i++) gap_ones += int'(wave[i]);
        check({tag, "_shape"}, bad_shape, 0);
        check({tag, "_gap"}, gap_ones, 0);
        check({tag, "_done"}, {fd_cnt[15:0], fd_last[15:0]}, {16'd1, 16'd1});
        check({tag, "_busy"}, busy_low, 0);
    endtask

    task automatic show_and_capture(input string tag);
        logic e;
        send_byte(8'h5A, e);
        capture_frame(tag);
        @(negedge clk);
        check({tag, "_idle"}, {busy, frame_done}, 2'b00);
    endtask

    initial begin
        logic e;
        int   seen, errcnt, cnt, pos;
        for (int l = 0; l < N; l++) exp_buf[l] = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset_out", {rz_data, busy, frame_done, cmd_err}, 4'b0000);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // All-zero chain.
        show_and_capture("t1");

        // LED0 red only.
        write_led(0, 8'hFF, 8'h00, 8'h00, "t2_wr");
        show_and_capture("t2");

        // Index out of range: error, buffer untouched.
        write_led(8, 8'h11, 8'h22, 8'h33, "t3_wr");
        show_and_capture("t3");

        // Inter-byte timeout.
        send_byte(8'hA5, e);
        send_byte(8'h03, e);
        send_byte(8'h10, e);
        seen   = -1;
        errcnt = 0;
        for (int k = 0; k <= TO + 20; k++) begin
            if (k > 0) @(negedge clk);
            if (cmd_err) begin
                if (seen < 0) seen = k;
                errcnt++;
            end
        end
        check("t4_latency", seen, TO);
        check("t4_err_once", errcnt, 1);
        write_led(3, 8'h01, 8'h02, 8'h03, "t4_wr");
        show_and_capture("t4");

        // Three shows during one frame give exactly two back-to-back frames.
        write_led(1, 8'h5A, 8'hA5, 8'h81, "t5_wr");
        send_byte(8'h5A, e);
        fork
            capture_frame("t5a");
            begin
                repeat (200) @(negedge clk);
                send_byte(8'h5A, e);
                repeat (300) @(negedge clk);
                send_byte(8'h5A, e);
            end
        join
        @(negedge clk);
        capture_frame("t5b");
        @(negedge clk);
        check("t5_end", {busy, frame_done}, 2'b00);
        cnt = 0;
        repeat (50) begin
            @(negedge clk);
            cnt += int'(busy);
        end
        check("t5_no_third", cnt, 0);

        // Randomised writes, junk bytes and shows.
        for (int it = 0; it < 40; it++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0) begin
                logic [7:0] jb;
                jb = 8'($urandom);
                if (jb == 8'hA5 || jb == 8'h5A) jb = 8'h00;
                send_byte(jb, e);
                check($sformatf("rnd%0d_junk", it), e, 0);
            end else if (r < 8) begin
                write_led($urandom_range(0, N + 1), rnd_byte(), rnd_byte(), rnd_byte(),
                          $sformatf("rnd%0d_wr", it));
            end else begin
                show_and_capture($sformatf("rnd%0d", it));
            end
        end
        show_and_capture("rnd_final");

        // Asynchronous reset in the middle of a high phase of LED 2.
        for (int l = 0; l < N; l++) write_led(l, 8'hFF, 8'hFF, 8'hFF, $sformatf("t6_wr%0d", l));
        send_byte(8'h5A, e);
        pos = 2 * 24 * BC + 5 * BC + 1;
        repeat (pos + 1) @(negedge clk);
        check("t6_pre_high", {busy, rz_data}, 2'b11);
        #2 rst_n = 1'b0;
        #1 check("t6_async", {rz_data, busy, frame_done}, 3'b000);
        for (int l = 0; l < N; l++) exp_buf[l] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (100) begin
            @(negedge clk);
            cnt += int'(frame_done) + int'(busy);
        end
        check("t6_quiet", cnt, 0);
        show_and_capture("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
